mcpu_core_stage_dtlb_chk: RTL and testbench

//  Parametrised data-TLB pipeline stage between decode/AGU (d2dtlb_*) and the PC/LSU stage (dtlb2pc_*).

---
 rtl/mcpu_core_stage_dtlb_chk.sv | 165 ++++++++++++++++
 tb/tb_mcpu_core_stage_dtlb_chk.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_stage_dtlb_chk.sv
// Data-TLB check stage: one TLB lookup per LSU op, then permission/alignment checks and paddr.
// Latency: 1 cycle with paging off or for non-LSU ops; with paging on, 1 cycle after dtlb_re plus any extra dtlb_ready=0 cycles.
// Backpressure: dtlb_stall is high while a lookup is outstanding; progress is ignored and no lookup is issued while it is high.
module mcpu_core_stage_dtlb_chk #(
  parameter int         VADDR_W       = 32,
  parameter int         PAGE_BITS     = 12,
  parameter int         FLAG_W        = 4,
  parameter logic [1:0] OPER_TYPE_LSU = 2'd1
) (
  input  logic                         clkrst_core_clk,
  input  logic                         clkrst_core_rst,
  input  logic [VADDR_W-1:0]           d2dtlb_vaddr,
  input  logic [1:0]                   d2dtlb_oper_type,
  input  logic                         d2dtlb_store,
  input  logic [1:0]                   d2dtlb_size,
  input  logic                         user_mode,
  input  logic                         paging_en,
  input  logic                         progress,
  output logic [VADDR_W-PAGE_BITS-1:0] dtlb_addr,
  output logic                         dtlb_re,
  input  logic [FLAG_W-1:0]            dtlb_flags,
  input  logic [VADDR_W-PAGE_BITS-1:0] dtlb_phys_addr,
  input  logic                         dtlb_ready,
  output logic [VADDR_W-1:0]           dtlb2pc_paddr,
  output logic                         dtlb2pc_pf,
  output logic [1:0]                   dtlb2pc_pf_cause,
  output logic                         dtlb2pc_misalign,
  output logic                         dtlb_stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOK = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PAGE_BITS-1:0]  offset_q;
  logic                  store_q;
  logic [1:0]            size_q;
  logic                  user_q;

  logic [VADDR_W-1:0]    paddr_d;
  logic                  pf_d;
  logic [1:0]            cause_d;
  logic                  mis_d;

  logic                  is_lsu;
  logic                  accept;

  // Flag bits above user are reserved and deliberately ignored.
  generate
    if (FLAG_W > 3) begin : g_rsvd_flags
      logic unused_rsvd_flags;
      assign unused_rsvd_flags = &{1'b0, dtlb_flags[FLAG_W-1:3]};
    end
  endgenerate

  // Byte accesses never fault; half needs bit0 clear; word (and size 3) needs bits[1:0] clear.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  assign is_lsu     = (d2dtlb_oper_type == OPER_TYPE_LSU);
  assign accept     = progress && (state_q == ST_IDLE);
  assign dtlb_addr  = d2dtlb_vaddr[VADDR_W-1:PAGE_BITS];
  assign dtlb_re    = accept && paging_en && is_lsu;
  assign dtlb_stall = (state_q != ST_IDLE);

  // State register; async reset abandons any outstanding lookup.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // Next state and next result/fault values; unchanged results hold their value.
  always_comb begin
    state_d = state_q;
    paddr_d = dtlb2pc_paddr;
    pf_d    = dtlb2pc_pf;
    cause_d = dtlb2pc_pf_cause;
    mis_d   = dtlb2pc_misalign;
    case (state_q)
      ST_IDLE: begin
        if (progress) begin
          if (is_lsu && paging_en) begin
            // A new op is latched: previous fault is cleared until the lookup returns.
            state_d = ST_LOOK;
            pf_d    = 1'b0;
            cause_d = 2'd0;
            mis_d   = 1'b0;
          end else if (is_lsu) begin
            paddr_d = d2dtlb_vaddr;
            mis_d   = is_misaligned(d2dtlb_size, d2dtlb_vaddr[1:0]);
            cause_d = mis_d ? 2'd3 : 2'd0;
            pf_d    = mis_d;
          end else begin
            paddr_d = d2dtlb_vaddr;
            pf_d    = 1'b0;
            cause_d = 2'd0;
            mis_d   = 1'b0;
          end
        end
      end
      ST_LOOK, ST_WAIT: begin
        if (dtlb_ready) begin
          state_d = ST_IDLE;
          paddr_d = {dtlb_phys_addr, offset_q};
          mis_d   = 1'b0;
          if (is_misaligned(size_q, offset_q[1:0])) begin
            cause_d = 2'd3;
            mis_d   = 1'b1;
          end else if (!dtlb_flags[0]) begin
            cause_d = 2'd1;
          end else if (user_q && !dtlb_flags[2]) begin
            cause_d = 2'd2;
          end else if (store_q && !dtlb_flags[1]) begin
            cause_d = 2'd3;
          end else begin
            cause_d = 2'd0;
          end
          pf_d = (cause_d != 2'd0);
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Op attributes are captured when the stage accepts an op.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      offset_q <= '0;
      store_q  <= 1'b0;
      size_q   <= 2'd0;
      user_q   <= 1'b0;
    end else if (accept) begin
      offset_q <= d2dtlb_vaddr[PAGE_BITS-1:0];
      store_q  <= d2dtlb_store;
      size_q   <= d2dtlb_size;
      user_q   <= user_mode;
    end
  end

  // Registered result towards the PC/LSU stage.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      dtlb2pc_paddr    <= '0;
      dtlb2pc_pf       <= 1'b0;
      dtlb2pc_pf_cause <= 2'd0;
      dtlb2pc_misalign <= 1'b0;
    end else begin
      dtlb2pc_paddr    <= paddr_d;
      dtlb2pc_pf       <= pf_d;
      dtlb2pc_pf_cause <= cause_d;
      dtlb2pc_misalign <= mis_d;
    end
  end

endmodule

// File: tb/tb_mcpu_core_stage_dtlb_chk.sv
// Bench for the data-TLB check stage: directed scenarios with literal expectations, then random traffic.
// Outputs are compared every falling edge against a behavioural model of the stage.
// Inputs change 2 time units after the rising edge.
module tb_mcpu_core_stage_dtlb_chk;

  localparam logic [1:0] LSU = 2'd1;

  logic        clk;
  logic        rst;
  logic [31:0] vaddr;
  logic [1:0]  oper;
  logic        store;
  logic [1:0]  size;
  logic        user;
  logic        paging;
  logic        progress;
  logic [19:0] dtlb_addr;
  logic        dtlb_re;
  logic [3:0]  flags;
  logic [19:0] frame;
  logic        ready;
  logic [31:0] paddr;
  logic        pf;
  logic [1:0]  cause;
  logic        mis;
  logic        stall;

  int checks   = 0;
  int failures = 0;
  int stall_cnt = 0;
  int re_cnt    = 0;
  logic re_seen;

  mcpu_core_stage_dtlb_chk #(
    .VADDR_W(32), .PAGE_BITS(12), .FLAG_W(4), .OPER_TYPE_LSU(LSU)
  ) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .d2dtlb_vaddr    (vaddr),
    .d2dtlb_oper_type(oper),
    .d2dtlb_store    (store),
    .d2dtlb_size     (size),
    .user_mode       (user),
    .paging_en       (paging),
    .progress        (progress),
    .dtlb_addr       (dtlb_addr),
    .dtlb_re         (dtlb_re),
    .dtlb_flags      (flags),
    .dtlb_phys_addr  (frame),
    .dtlb_ready      (ready),
    .dtlb2pc_paddr   (paddr),
    .dtlb2pc_pf      (pf),
    .dtlb2pc_pf_cause(cause),
    .dtlb2pc_misalign(mis),
    .dtlb_stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_busy;
  logic [31:0] m_paddr;
  logic        m_pf;
  logic [1:0]  m_cause;
  logic        m_mis;
  logic [31:0] p_vaddr;
  logic        p_store;
  logic [1:0]  p_size;
  logic        p_user;

  function automatic bit bad_align(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_paddr = 0; m_pf = 0; m_cause = 0; m_mis = 0;
    end else if (!m_busy) begin
      if (progress) begin
        if (oper == LSU && paging) begin
          m_busy = 1; p_vaddr = vaddr; p_store = store; p_size = size; p_user = user;
          m_pf = 0; m_cause = 0; m_mis = 0;
        end else begin
          m_paddr = vaddr;
          m_mis   = (oper == LSU) && bad_align(size, vaddr);
          m_cause = m_mis ? 2'd3 : 2'd0;
          m_pf    = m_mis;
        end
      end
    end else if (ready) begin
      m_paddr = (32'(frame) * 4096) + (p_vaddr % 4096);
      m_mis   = 0;
      if (bad_align(p_size, p_vaddr))  begin m_cause = 3; m_mis = 1; end
      else if (flags[0] == 0)          m_cause = 1;
      else if (p_user && !flags[2])    m_cause = 2;
      else if (p_store && !flags[1])   m_cause = 3;
      else                             m_cause = 0;
      m_pf   = (m_cause != 0);
      m_busy = 0;
    end
  end

  // Per-cycle comparison against the model; result outputs are meaningful only when not stalled.
  always @(negedge clk) begin
    if (!rst) begin
      chk("re", dtlb_re, progress && !m_busy && paging && (oper == LSU));
      chk("tag", dtlb_addr, vaddr / 4096);
      chk("stall", stall, m_busy);
      if (!m_busy) begin
        chk("paddr", paddr, m_paddr);
        chk("pf", pf, m_pf);
        chk("cause", cause, m_cause);
        chk("misalign", mis, m_mis);
      end
      if (stall)   stall_cnt++;
      if (dtlb_re) re_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [31:0] va, input logic st, input logic [1:0] sz,
                    input logic us, input logic pg, input logic [1:0] ot);
    tick();
    vaddr = va; store = st; size = sz; user = us; paging = pg; oper = ot; progress = 1;
    #1 re_seen = dtlb_re;
    tick();
    progress = 0;
  endtask

  // Hold ready low for dly cycles (pulsing progress if asked), then one ready cycle.
  task automatic respond(input logic [19:0] fr, input logic [3:0] fl, input int dly, input bit poke);
    for (int i = 0; i < dly; i++) begin
      progress = poke;
      tick();
    end
    progress = 0;
    frame = fr; flags = fl; ready = 1;
    tick();
    ready = 0;
    @(negedge clk);
  endtask

  task automatic fault_case(input string nm, input logic [31:0] va, input logic st, input logic [1:0] sz,
                            input logic us, input logic [3:0] fl,
                            input logic epf, input logic [1:0] ec, input logic em);
    op(va, st, sz, us, 1'b1, LSU);
    respond(20'h8_0001, fl, 0, 0);
    chk({nm, "_pf"}, pf, epf);
    chk({nm, "_cause"}, cause, ec);
    chk({nm, "_mis"}, mis, em);
  endtask

  initial begin
    int s0, r0;
    rst = 1; vaddr = 0; oper = 0; store = 0; size = 0; user = 0; paging = 0;
    progress = 0; flags = 0; frame = 0; ready = 0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pf", pf, 1'b0);
    chk("rst_cause", cause, 2'd0);
    chk("rst_mis", mis, 1'b0);
    chk("rst_stall", stall, 1'b0);

    // 1: paging off, identity map, no lookup
    r0 = re_cnt;
    op(32'h1234_5678, 0, 2'd2, 0, 1'b0, LSU);
    @(negedge clk);
    chk("t1_paddr", paddr, 32'h1234_5678);
    chk("t1_pf", pf, 1'b0);
    chk("t1_re", re_cnt - r0, 0);

    // 2: single-cycle lookup
    s0 = stall_cnt;
    op(32'h0040_0ABC, 0, 2'd2, 0, 1'b1, LSU);
    chk("t2_re", re_seen, 1'b1);
    respond(20'h8_0001, 4'b0111, 0, 0);
    chk("t2_paddr", paddr, 32'h8000_1ABC);
    chk("t2_pf", pf, 1'b0);
    chk("t2_stall_cycles", stall_cnt - s0, 1);

    // 3: three ready-low cycles with misbehaving progress pulses
    s0 = stall_cnt; r0 = re_cnt;
    op(32'h0040_0ABC, 0, 2'd2, 0, 1'b1, LSU);
    respond(20'h8_0001, 4'b0111, 3, 1);
    chk("t3_paddr", paddr, 32'h8000_1ABC);
    chk("t3_stall_cycles", stall_cnt - s0, 4);
    chk("t3_re_count", re_cnt - r0, 1);

    // 4: fault priority for a user-mode store
    fault_case("t4_priv",  32'h0040_0AB0, 1, 2'd2, 1, 4'b0011, 1, 2'd2, 0);
    fault_case("t4_wp",    32'h0040_0AB0, 1, 2'd2, 1, 4'b0101, 1, 2'd3, 0);
    fault_case("t4_np",    32'h0040_0AB0, 1, 2'd2, 1, 4'b0000, 1, 2'd1, 0);

    // 5: alignment
    fault_case("t5_word",  32'h0040_0002, 0, 2'd2, 0, 4'b0111, 1, 2'd3, 1);
    fault_case("t5_half",  32'h0040_0001, 0, 2'd1, 0, 4'b0111, 1, 2'd3, 1);
    fault_case("t5_byte",  32'h0040_0003, 0, 2'd0, 0, 4'b0111, 0, 2'd0, 0);

    // 6: reset during WAIT, then a stale ready
    op(32'h0040_0ABC, 0, 2'd2, 0, 1'b1, LSU);
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    frame = 20'h8_0001; flags = 4'b0000; ready = 1;
    tick();
    ready = 0;
    @(negedge clk);
    chk("t6_paddr", paddr, 32'h0);
    chk("t6_pf", pf, 1'b0);
    chk("t6_cause", cause, 2'd0);
    chk("t6_stall", stall, 1'b0);
    op(32'h0040_0ABC, 0, 2'd2, 0, 1'b1, LSU);
    chk("t6_re", re_seen, 1'b1);
    respond(20'h8_0001, 4'b0111, 0, 0);
    chk("t6_next_paddr", paddr, 32'h8000_1ABC);
    chk("t6_next_pf", pf, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst      = ($urandom_range(0, 399) == 0);
      progress = $urandom_range(0, 1);
      oper     = ($urandom_range(0, 3) != 0) ? LSU : 2'($urandom_range(0, 3));
      paging   = ($urandom_range(0, 3) != 0);
      vaddr    = $urandom;
      store    = $urandom_range(0, 1);
      size     = 2'($urandom_range(0, 3));
      user     = $urandom_range(0, 1);
      ready    = ($urandom_range(0, 4) < 2);
      frame    = 20'($urandom);
      flags    = 4'($urandom);
    end
    tick();
    rst = 0; progress = 0; ready = 0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
